// File: rtl/prince_mask_pkg.sv
// Shared types, PRINCE S-box tables and ANF helper for the masked PRINCE datapath.
package prince_mask_pkg;

   localparam int unsigned NSH    = 2;
   localparam int unsigned NCOMP  = 16;
   localparam int unsigned RAND_W = 64;

   typedef logic [3:0]     nib_t;
   typedef nib_t [NSH-1:0] shares_t;

   localparam nib_t PRINCE_SBOX [16] = '{
      4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
      4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
   };

   localparam nib_t PRINCE_SBOX_INV [16] = '{
      4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
      4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
   };

   // Moebius transform: bit m of the result is the ANF coefficient of monomial m for output bit b.
   function automatic logic [15:0] inv_anf(input int unsigned b);
      logic [15:0] f;
      f = '0;
      for (int unsigned i = 0; i < 16; i++)
         f[i[3:0]] = PRINCE_SBOX_INV[i[3:0]][b[1:0]];
      for (int unsigned j = 0; j < 4; j++)
         for (int unsigned i = 0; i < 16; i++)
            if (i[j[1:0]])
               f[i[3:0]] = f[i[3:0]] ^ f[i[3:0] ^ (4'b1 << j[1:0])];
      return f;
   endfunction

endpackage

// File: rtl/s_inv_bit_comp.sv
// One CMS component of S^-1 output bit BIT, for share-index tuple T (bit v of T = share used for variable v).
module s_inv_bit_comp
   import prince_mask_pkg::*;
#(
   parameter int unsigned BIT = 0,
   parameter int unsigned T   = 0
) (
   input  logic [3:0] sh_i,
   output logic       comp_o
);

   localparam logic [15:0] ANF = inv_anf(BIT);
   localparam logic [3:0]  TUP = T[3:0];

   // A cross term of monomial m lands here only if T picks share 0 for every variable outside m.
   always_comb begin
      comp_o = 1'b0;
      for (int unsigned m = 0; m < 16; m++) begin
         if (ANF[m[3:0]] && ((TUP & ~m[3:0]) == 4'b0000))
            comp_o = comp_o ^ (&(sh_i | ~m[3:0]));
      end
   end

endmodule

// File: rtl/prince_sbox_inv_cms_pipe.sv
// Two-stage, 2-share CMS masked PRINCE inverse S-box with valid/ready on both sides.
module prince_sbox_inv_cms_pipe
   import prince_mask_pkg::*;
#(
   parameter int unsigned NSH    = 2,
   parameter int unsigned NCOMP  = 16,
   parameter int unsigned RAND_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_sh0,
   input  logic [3:0]        in_sh1,
   input  logic [RAND_W-1:0] in_rand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_sh0,
   output logic [3:0]        out_sh1
);

   if (NSH != 2) begin : g_nsh_chk
      $error("prince_sbox_inv_cms_pipe: NSH must be 2");
   end
   if (NCOMP != prince_mask_pkg::NCOMP || RAND_W != 4 * NCOMP) begin : g_width_chk
      $error("prince_sbox_inv_cms_pipe: NCOMP must be 16 and RAND_W must be 64");
   end
   for (genvar i = 0; i < 16; i++) begin : g_tbl_chk
      if (PRINCE_SBOX_INV[PRINCE_SBOX[i]] != 4'(i)) begin : g_bad
         $error("prince_sbox_inv_cms_pipe: inverse S-box table mismatch");
      end
   end

   shares_t               in_sh;
   logic [3:0][NCOMP-1:0] comp, c_ref, c_d, c_q;
   logic                  s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;
   nib_t                  sh0_d, sh0_q, sh1_d, sh1_q;
   logic                  s2_adv, accept;

   assign in_sh[0] = in_sh0;
   assign in_sh[1] = in_sh1;

   for (genvar b = 0; b < 4; b++) begin : g_bit
      for (genvar t = 0; t < NCOMP; t++) begin : g_comp
         logic [3:0] sel;
         for (genvar v = 0; v < 4; v++) begin : g_var
            localparam int unsigned S = (t >> v) & 1;
            assign sel[v] = in_sh[S[0]][v];
         end
         s_inv_bit_comp #(.BIT(b), .T(t)) u_comp (
            .sh_i   (sel),
            .comp_o (comp[b][t])
         );
         // Ring refresh: each mask bit enters two neighbouring components, so it cancels in the total.
         assign c_ref[b][t] = comp[b][t] ^ in_rand[NCOMP*b + t] ^ in_rand[NCOMP*b + (t + 1) % NCOMP];
      end
   end

   assign s2_adv   = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;
   assign accept   = in_valid && in_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      c_d         = c_q;
      out_valid_d = out_valid_q;
      sh0_d       = sh0_q;
      sh1_d       = sh1_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         c_d        = c_ref;
      end else if (s2_adv) begin
         s1_valid_d = 1'b0;
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
               sh0_d[b[1:0]] = ^c_q[b[1:0]][NCOMP/2-1:0];
               sh1_d[b[1:0]] = ^c_q[b[1:0]][NCOMP-1:NCOMP/2];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         c_q         <= '0;
         out_valid_q <= 1'b0;
         sh0_q       <= '0;
         sh1_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         c_q         <= c_d;
         out_valid_q <= out_valid_d;
         sh0_q       <= sh0_d;
         sh1_q       <= sh1_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sh0   = sh0_q;
   assign out_sh1   = sh1_q;

endmodule

// File: tb/tb_prince_sbox_inv_cms_pipe.sv
// Randomised self-checking bench: unmasked-value scoreboard, latency, back-pressure, re-sharing and async reset.
module tb_prince_sbox_inv_cms_pipe;

   localparam logic [3:0] SINV [16] = '{
      4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
      4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  in_sh0, in_sh1, out_sh0, out_sh1;
   logic [63:0] in_rand;

   always #5 clk = ~clk;

   prince_sbox_inv_cms_pipe #(.NSH(2), .NCOMP(16), .RAND_W(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sh0    (in_sh0),
      .in_sh1    (in_sh1),
      .in_rand   (in_rand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sh0   (out_sh0),
      .out_sh1   (out_sh1)
   );

   int          total = 0;
   int          bad = 0;
   logic [3:0]  exp_q [$];
   int          cyc, n_out, n_acc, first_out_cyc, last_out_cyc;
   logic        acc_s, ov_s, hold_prev, rnd_ready;
   logic [3:0]  sh0_s, x_s, hold_sh0, hold_sh1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Only the ring masks of components 0..7 differ between two runs with identical input shares.
   function automatic logic [3:0] mdelta(input logic [63:0] r);
      logic [63:0] s;
      logic [3:0]  d;
      d = '0;
      for (int unsigned b = 0; b < 4; b++) begin
         s = r >> (16 * b);
         d[b[1:0]] = s[0] ^ s[8];
      end
      return d;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [63:0] r);
      in_valid = v;
      in_sh0   = a;
      in_sh1   = b;
      in_rand  = r;
   endtask

   task automatic step();
      @(negedge clk);
      ov_s  = out_valid;
      acc_s = in_valid && in_ready;
      if (hold_prev) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_sh0", out_sh0, hold_sh0);
         chk("hold_sh1", out_sh1, hold_sh1);
      end
      hold_prev = out_valid && !out_ready;
      hold_sh0  = out_sh0;
      hold_sh1  = out_sh1;
      if (out_valid && out_ready) begin
         sh0_s = out_sh0;
         x_s   = out_sh0 ^ out_sh1;
         if (n_out == 0) first_out_cyc = cyc;
         last_out_cyc = cyc;
         n_out++;
         chk("drain_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("unmasked", x_s, exp_q.pop_front());
      end
      if (acc_s) begin
         exp_q.push_back(SINV[in_sh0 ^ in_sh1]);
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [63:0] r);
      int unsigned k;
      drive(1'b1, a, b, r);
      k = 0;
      acc_s = 1'b0;
      while (!acc_s && k < 50) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      chk("send_accepted", acc_s, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20 && (out_valid || exp_q.size() != 0); k++) step();
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [63:0] r, output logic [3:0] s0);
      out_ready = 1'b1;
      send(a, b, r);
      drain();
      s0 = sh0_s;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  a, x, s_a, s_b, s_c;
      logic [63:0] r1, r2;

      hold_prev = 1'b0;
      rnd_ready = 1'b0;
      n_out = 0;
      n_acc = 0;
      cyc = 0;
      first_out_cyc = -1;
      last_out_cyc = -1;
      sh0_s = '0;
      x_s = '0;
      out_ready = 1'b1;
      drive(1'b0, 4'h0, 4'h0, 64'h0);

      // reset state
      #3;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_sh0", out_sh0, 4'h0);
      chk("rst_out_sh1", out_sh1, 4'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // latency of a single transfer, sh0=3 sh1=6 -> S^-1(5) = D
      cyc = 0;
      n_out = 0;
      drive(1'b1, 4'h3, 4'h6, rnd64());
      step();
      chk("lat_accept", acc_s, 1'b1);
      in_valid = 1'b0;
      step();
      chk("lat_cycle1_valid", ov_s, 1'b0);
      step();
      chk("lat_cycle2_valid", ov_s, 1'b1);
      chk("lat_value", x_s, 4'hD);
      drain();

      // 16 back-to-back inputs -> outputs in cycles 2..17
      cyc = 0;
      n_out = 0;
      n_acc = 0;
      for (int i = 0; i < 16; i++) begin
         a = 4'($urandom);
         x = 4'(i);
         drive(1'b1, a, a ^ x, rnd64());
         step();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 30 && n_out < 16; k++) step();
      chk("b2b_accepts", n_acc, 16);
      chk("b2b_outputs", n_out, 16);
      chk("b2b_first_cycle", first_out_cyc, 2);
      chk("b2b_last_cycle", last_out_cyc, 17);

      // back-pressure: 5 stalled cycles, then simultaneous accept and drain
      n_acc = 0;
      n_out = 0;
      out_ready = 1'b0;
      a = 4'($urandom);
      drive(1'b1, a, 4'($urandom), rnd64());
      for (int k = 0; k < 5; k++) begin
         step();
         if (acc_s) drive(1'b1, 4'($urandom), 4'($urandom), rnd64());
      end
      chk("bp_accepts", n_acc, 2);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_no_output", n_out, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (acc_s) drive(1'b1, 4'($urandom), 4'($urandom), rnd64());
      end
      chk("bp_no_bubble_accepts", n_acc, 5);
      drain();
      chk("bp_outputs", n_out, 5);

      // exhaustive share pairs with random randomness and random downstream stalls
      n_out = 0;
      rnd_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         r1 = rnd64();
         send(4'(i >> 4), 4'(i), r1);
      end
      rnd_ready = 1'b0;
      drain();
      chk("exh_outputs", n_out, 256);

      // re-sharing: identical input shares, different randomness
      r1 = 64'h0;
      r2 = 64'hFFFF_0000_1234_5678;
      single(4'h0, 4'h0, r1, s_a);
      chk("reshare_a_value", x_s, 4'hB);
      single(4'h0, 4'h0, r2, s_b);
      chk("reshare_b_value", x_s, 4'hB);
      chk("reshare_ab_delta", s_a ^ s_b, mdelta(r1 ^ r2));
      single(4'h0, 4'h0, 64'h0001_0100_0001_0100, s_c);
      chk("reshare_c_delta", s_a ^ s_c, 4'hF);
      for (int i = 0; i < 8; i++) begin
         a = 4'($urandom);
         x = 4'($urandom);
         r1 = rnd64();
         r2 = rnd64();
         single(a, a ^ x, r1, s_a);
         single(a, a ^ x, r2, s_b);
         chk("reshare_rand_delta", s_a ^ s_b, mdelta(r1 ^ r2));
      end

      // asynchronous reset in the middle of a stream
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'($urandom), 4'($urandom), rnd64());
         step();
      end
      chk("pre_reset_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_sh0", out_sh0, 4'h0);
      chk("async_rst_sh1", out_sh1, 4'h0);
      in_valid = 1'b0;
      exp_q.delete();
      hold_prev = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      step();
      chk("post_rst_idle", ov_s, 1'b0);
      cyc = 0;
      n_out = 0;
      drive(1'b1, 4'h9, 4'h3, rnd64());
      step();
      chk("post_rst_accept", acc_s, 1'b1);
      in_valid = 1'b0;
      step();
      chk("post_rst_cycle1_valid", ov_s, 1'b0);
      step();
      chk("post_rst_cycle2_valid", ov_s, 1'b1);
      chk("post_rst_value", x_s, SINV[4'hA]);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
